// File: rtl/frame_fifo_pkg.sv
// Shared definitions for the frame reader/writer pair: FSM encoding and burst defaults.
package frame_fifo_pkg;

  localparam int BURST_SIZE_DEFAULT = 16;
  localparam int BUSRT_BITS_DEFAULT = 10;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_ACK            = 3'd1,
    S_CHECK_FIFO     = 3'd2,
    S_READ_BURST     = 3'd3,
    S_READ_BURST_END = 3'd4,
    S_END            = 3'd5
  } state_t;

endpackage

// File: rtl/frame_fifo_req_sync.sv
// Request synchronizer: 3-flop pulse/level path for the request, 2-flop path for the
// quasi-static bus that accompanies it (length, index).
module req_sync #(
  parameter int BUS_BITS = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [BUS_BITS-1:0] bus,
  output logic                req_d2,
  output logic [BUS_BITS-1:0] bus_d1
);

  logic [2:0]          req_pipe;
  logic [BUS_BITS-1:0] bus_d0;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pipe <= '0;
      bus_d0   <= '0;
      bus_d1   <= '0;
    end else begin
      req_pipe <= {req_pipe[1:0], req};
      bus_d0   <= bus;
      bus_d1   <= bus_d0;
    end
  end

  assign req_d2 = req_pipe[2];

endmodule

// File: rtl/frame_fifo_read.sv
// Frame reader: sequences burst reads from external memory into the display FIFO,
// issuing a burst only when the FIFO has room for all of its words.
module frame_fifo_read
  import frame_fifo_pkg::*;
#(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BUSRT_BITS    = BUSRT_BITS_DEFAULT,
  parameter int BURST_SIZE    = BURST_SIZE_DEFAULT,
  parameter int FIFO_DEPTH    = 512
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  output logic                  rd_burst_req,
  output logic [BUSRT_BITS-1:0] rd_burst_len,
  output logic [ADDR_BITS-1:0]  rd_burst_addr,
  input  logic                  rd_burst_data_valid,
  input  logic                  rd_burst_finish,
  input  logic                  read_req,
  output logic                  read_req_ack,
  output logic                  read_finish,
  input  logic [ADDR_BITS-1:0]  read_addr_0,
  input  logic [ADDR_BITS-1:0]  read_addr_1,
  input  logic                  read_addr_index,
  input  logic [ADDR_BITS-1:0]  read_len,
  output logic                  fifo_aclr,
  input  logic [15:0]           wrusedw
);

  if (MEM_DATA_BITS % 8 != 0) begin : g_bad_data_width
    $error("MEM_DATA_BITS must be a whole number of bytes");
  end
  if (BURST_SIZE < 1 || BURST_SIZE >= (1 << BUSRT_BITS) || BUSRT_BITS > ADDR_BITS) begin : g_bad_burst
    $error("BURST_SIZE must fit in BUSRT_BITS, and BUSRT_BITS must not exceed ADDR_BITS");
  end

  state_t                 state;
  logic                   req_d2;
  logic [ADDR_BITS:0]     sync_bus;
  logic [ADDR_BITS-1:0]   len_sync;
  logic                   index_sync;
  logic [ADDR_BITS-1:0]   len_latch;
  logic [ADDR_BITS-1:0]   read_cnt;
  logic [ADDR_BITS-1:0]   remaining;
  logic [BUSRT_BITS-1:0]  len_next;
  logic [BUSRT_BITS-1:0]  beat_cnt;
  logic [BUSRT_BITS-1:0]  beat_total;
  logic [16:0]            space_sum;
  logic                   space_ok;
  logic                   beat_mismatch;

  req_sync #(
    .BUS_BITS(ADDR_BITS + 1)
  ) u_req_sync (
    .clk   (mem_clk),
    .rst   (rst),
    .req   (read_req),
    .bus   ({read_addr_index, read_len}),
    .req_d2(req_d2),
    .bus_d1(sync_bus)
  );

  assign len_sync   = sync_bus[ADDR_BITS-1:0];
  assign index_sync = sync_bus[ADDR_BITS];

  // The last burst of a frame is trimmed to whatever words remain.
  assign remaining = len_latch - read_cnt;
  assign len_next  = (remaining > ADDR_BITS'(BURST_SIZE)) ? BUSRT_BITS'(BURST_SIZE)
                                                          : remaining[BUSRT_BITS-1:0];

  // 17-bit sum so a nearly full FIFO cannot wrap the comparison.
  assign space_sum = {1'b0, wrusedw} + 17'(len_next);
  assign space_ok  = (space_sum <= 17'(FIFO_DEPTH));

  assign beat_total    = beat_cnt + BUSRT_BITS'(rd_burst_data_valid);
  assign beat_mismatch = (state == S_READ_BURST) && rd_burst_finish && (beat_total != rd_burst_len);

  assign read_finish = (state == S_END);

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rd_burst_req  <= 1'b0;
      rd_burst_len  <= '0;
      rd_burst_addr <= '0;
      read_req_ack  <= 1'b0;
      fifo_aclr     <= 1'b0;
      len_latch     <= '0;
      read_cnt      <= '0;
      beat_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          read_req_ack <= 1'b0;
          if (req_d2) begin
            state <= S_ACK;
          end
        end
        S_ACK: begin
          read_cnt <= '0;
          if (req_d2) begin
            read_req_ack  <= 1'b1;
            fifo_aclr     <= 1'b1;
            rd_burst_addr <= index_sync ? read_addr_1 : read_addr_0;
            len_latch     <= len_sync;
          end else begin
            read_req_ack <= 1'b0;
            fifo_aclr    <= 1'b0;
            state        <= S_CHECK_FIFO;
          end
        end
        S_CHECK_FIFO: begin
          if (req_d2) begin
            state <= S_ACK;
          end else if (read_cnt >= len_latch) begin
            state <= S_END;
          end else if (space_ok) begin
            rd_burst_len <= len_next;
            rd_burst_req <= 1'b1;
            beat_cnt     <= '0;
            state        <= S_READ_BURST;
          end
        end
        S_READ_BURST: begin
          // A started burst always runs to completion; restarts wait for its end.
          if (rd_burst_data_valid) begin
            beat_cnt <= beat_total;
          end
          if (rd_burst_finish) begin
            rd_burst_req  <= 1'b0;
            read_cnt      <= read_cnt + ADDR_BITS'(rd_burst_len);
            rd_burst_addr <= rd_burst_addr + ADDR_BITS'(rd_burst_len);
            state         <= S_READ_BURST_END;
          end
        end
        S_READ_BURST_END: begin
          if (req_d2) begin
            state <= S_ACK;
          end else if (read_cnt < len_latch) begin
            state <= S_CHECK_FIFO;
          end else begin
            state <= S_END;
          end
        end
        S_END: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The controller must deliver exactly rd_burst_len words per burst.
  always_ff @(posedge mem_clk) begin
    if (!rst) begin
      assert (!beat_mismatch);
    end
  end

endmodule

// File: tb/tb_frame_fifo_read.sv
// Directed bench for frame_fifo_read: a small controller model answers burst requests
// and each scenario task checks handshake timing, burst addresses/lengths and finish.
module tb_frame_fifo_read;
  import frame_fifo_pkg::*;

  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [22:0] rd_burst_addr;
  logic        rd_burst_data_valid = 1'b0;
  logic        rd_burst_finish = 1'b0;
  logic        read_req = 1'b0;
  logic        read_req_ack;
  logic        read_finish;
  logic [22:0] read_addr_0 = 23'h001000;
  logic [22:0] read_addr_1 = 23'h000000;
  logic        read_addr_index = 1'b0;
  logic [22:0] read_len = 23'd0;
  logic        fifo_aclr;
  logic [15:0] wrusedw = 16'd0;

  int total = 0;
  int bad = 0;

  always #5 mem_clk = ~mem_clk;

  frame_fifo_read dut (
    .mem_clk            (mem_clk),
    .rst                (rst),
    .rd_burst_req       (rd_burst_req),
    .rd_burst_len       (rd_burst_len),
    .rd_burst_addr      (rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_finish    (rd_burst_finish),
    .read_req           (read_req),
    .read_req_ack       (read_req_ack),
    .read_finish        (read_finish),
    .read_addr_0        (read_addr_0),
    .read_addr_1        (read_addr_1),
    .read_addr_index    (read_addr_index),
    .read_len           (read_len),
    .fifo_aclr          (fifo_aclr),
    .wrusedw            (wrusedw)
  );

  // Drop the request and watch ack/aclr fall together after 3 more high cycles.
  task automatic finish_handshake(input string tag);
    int high_cycles;
    bit dropped;
    high_cycles = 0;
    dropped = 1'b0;
    read_req = 1'b0;
    for (int i = 0; i < 20 && !dropped; i++) begin
      @(negedge mem_clk);
      total++;
      if (read_req_ack) begin
        high_cycles++;
        if (fifo_aclr !== 1'b1) begin
          bad++;
          $display("FAIL %s_aclr_high: fifo_aclr=%b required 1 while ack high", tag, fifo_aclr);
        end
      end else begin
        dropped = 1'b1;
        if (fifo_aclr !== 1'b0) begin
          bad++;
          $display("FAIL %s_aclr_low: fifo_aclr=%b required 0 after ack", tag, fifo_aclr);
        end
      end
    end
    total++;
    if (!dropped || high_cycles != 3) begin
      bad++;
      $display("FAIL %s_ack_tail: ack stayed high %0d more cycles (dropped=%0b) required 3", tag, high_cycles, dropped);
    end
    $display("handshake %s: ack tail %0d cycles", tag, high_cycles);
  endtask

  task automatic request_frame(input logic idx, input logic [22:0] len, input string tag);
    int lat;
    lat = 0;
    read_addr_index = idx;
    read_len = len;
    read_req = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge mem_clk);
      total++;
      if (read_req_ack === 1'b1) begin
        lat = i;
        if (fifo_aclr !== 1'b1) begin
          bad++;
          $display("FAIL %s_aclr_rise: fifo_aclr=%b required 1 with ack", tag, fifo_aclr);
        end
      end else if (fifo_aclr !== 1'b0) begin
        bad++;
        $display("FAIL %s_aclr_early: fifo_aclr=%b required 0 before ack", tag, fifo_aclr);
      end
    end
    total++;
    if (lat != 5) begin
      bad++;
      $display("FAIL %s_ack_latency: got %0d cycles required 5", tag, lat);
    end
    $display("request %s: idx=%0b len=%0d ack latency %0d", tag, idx, len, lat);
    finish_handshake(tag);
  endtask

  // Controller model: wait for a request, check it, deliver len beats, finish on the last.
  task automatic serve_burst(input logic [22:0] addr, input logic [9:0] len, input bit raise_req,
                             input string tag);
    int waited;
    waited = 0;
    while (rd_burst_req !== 1'b1 && waited < 60) begin
      @(negedge mem_clk);
      waited++;
    end
    total++;
    if (rd_burst_req !== 1'b1) begin
      bad++;
      $display("FAIL %s_req_timeout: rd_burst_req=%b required 1 within 60 cycles", tag, rd_burst_req);
      return;
    end
    total++;
    if (rd_burst_addr !== addr || rd_burst_len !== len) begin
      bad++;
      $display("FAIL %s_burst: addr=%h len=%0d required addr=%h len=%0d", tag, rd_burst_addr,
               rd_burst_len, addr, len);
    end
    if (raise_req) read_req = 1'b1;
    for (int b = 0; b < int'(len); b++) begin
      total++;
      if (rd_burst_req !== 1'b1) begin
        bad++;
        $display("FAIL %s_req_hold: rd_burst_req=%b at beat %0d required 1", tag, rd_burst_req, b);
      end
      rd_burst_data_valid = 1'b1;
      rd_burst_finish = (b == int'(len) - 1);
      @(negedge mem_clk);
    end
    rd_burst_data_valid = 1'b0;
    rd_burst_finish = 1'b0;
    total++;
    if (rd_burst_req !== 1'b0) begin
      bad++;
      $display("FAIL %s_req_drop: rd_burst_req=%b required 0 after finish", tag, rd_burst_req);
    end
    $display("burst %s: addr=%h len=%0d wait=%0d", tag, addr, len, waited);
  endtask

  task automatic wait_finish(input string tag);
    @(negedge mem_clk);
    total++;
    if (read_finish !== 1'b1) begin
      bad++;
      $display("FAIL %s_finish: read_finish=%b required 1", tag, read_finish);
    end
    @(negedge mem_clk);
    total++;
    if (read_finish !== 1'b0 || rd_burst_req !== 1'b0) begin
      bad++;
      $display("FAIL %s_finish_pulse: read_finish=%b rd_burst_req=%b required 0 0", tag,
               read_finish, rd_burst_req);
    end
    $display("frame %s: finished", tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if (rd_burst_req !== 1'b0 || rd_burst_len !== 10'd0 || rd_burst_addr !== 23'd0 ||
        read_req_ack !== 1'b0 || read_finish !== 1'b0 || fifo_aclr !== 1'b0 ||
        dut.state !== S_IDLE) begin
      bad++;
      $display("FAIL %s: req=%b len=%0d addr=%h ack=%b fin=%b aclr=%b state=%0d required all 0, S_IDLE",
               tag, rd_burst_req, rd_burst_len, rd_burst_addr, read_req_ack, read_finish,
               fifo_aclr, dut.state);
    end
    $display("reset check %s", tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge mem_clk);
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(negedge mem_clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_basic_frame();
    wrusedw = 16'd0;
    request_frame(1'b0, 23'd64, "basic");
    for (int k = 0; k < 4; k++) serve_burst(23'h001000 + 23'(16 * k), 10'd16, 1'b0, "basic");
    wait_finish("basic");
  endtask

  task automatic test_short_tail();
    request_frame(1'b0, 23'd40, "tail");
    serve_burst(23'h001000, 10'd16, 1'b0, "tail");
    serve_burst(23'h001010, 10'd16, 1'b0, "tail");
    serve_burst(23'h001020, 10'd8, 1'b0, "tail");
    wait_finish("tail");
    total++;
    if (rd_burst_len !== 10'd8 || rd_burst_addr !== 23'h001028) begin
      bad++;
      $display("FAIL tail_final: len=%0d addr=%h required 8 001028", rd_burst_len, rd_burst_addr);
    end
  endtask

  task automatic test_back_pressure();
    wrusedw = 16'd500;
    request_frame(1'b0, 23'd16, "bp");
    for (int i = 0; i < 8; i++) begin
      @(negedge mem_clk);
      total++;
      if (rd_burst_req !== 1'b0) begin
        bad++;
        $display("FAIL bp_blocked_500: rd_burst_req=%b required 0", rd_burst_req);
      end
    end
    wrusedw = 16'd497;
    for (int i = 0; i < 4; i++) begin
      @(negedge mem_clk);
      total++;
      if (rd_burst_req !== 1'b0) begin
        bad++;
        $display("FAIL bp_blocked_497: rd_burst_req=%b required 0", rd_burst_req);
      end
    end
    wrusedw = 16'd496;
    @(negedge mem_clk);
    total++;
    if (rd_burst_req !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: rd_burst_req=%b required 1 one cycle after space", rd_burst_req);
    end
    serve_burst(23'h001000, 10'd16, 1'b0, "bp");
    wait_finish("bp");
    wrusedw = 16'd0;
  endtask

  task automatic test_index_select();
    read_addr_1 = 23'h7F0000;
    request_frame(1'b1, 23'd16, "index");
    serve_burst(23'h7F0000, 10'd16, 1'b0, "index");
    wait_finish("index");
  endtask

  task automatic test_zero_length();
    request_frame(1'b0, 23'd0, "zero");
    wait_finish("zero");
  endtask

  task automatic test_restart();
    request_frame(1'b0, 23'd64, "restart");
    serve_burst(23'h001000, 10'd16, 1'b0, "restart_b1");
    serve_burst(23'h001010, 10'd16, 1'b1, "restart_b2");
    @(negedge mem_clk);
    total++;
    if (read_req_ack !== 1'b0 || rd_burst_req !== 1'b0) begin
      bad++;
      $display("FAIL restart_gap: ack=%b req=%b required 0 0", read_req_ack, rd_burst_req);
    end
    @(negedge mem_clk);
    total++;
    if (read_req_ack !== 1'b1 || dut.state !== S_ACK) begin
      bad++;
      $display("FAIL restart_ack: ack=%b state=%0d required 1 S_ACK", read_req_ack, dut.state);
    end
    finish_handshake("restart");
    for (int k = 0; k < 4; k++) serve_burst(23'h001000 + 23'(16 * k), 10'd16, 1'b0, "restart_again");
    wait_finish("restart");
  endtask

  task automatic test_reset_mid_burst();
    int waited;
    waited = 0;
    read_addr_index = 1'b0;
    read_len = 23'd64;
    read_req = 1'b1;
    while (read_req_ack !== 1'b1 && waited < 20) begin
      @(negedge mem_clk);
      waited++;
    end
    read_req = 1'b0;
    waited = 0;
    while (rd_burst_req !== 1'b1 && waited < 40) begin
      @(negedge mem_clk);
      waited++;
    end
    total++;
    if (rd_burst_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_req: rd_burst_req=%b required 1", rd_burst_req);
    end
    rd_burst_data_valid = 1'b1;
    repeat (3) @(negedge mem_clk);
    rd_burst_data_valid = 1'b0;
    rst = 1'b1;
    @(negedge mem_clk);
    rst = 1'b0;
    check_idle_outputs("reset_mid_burst");
    @(negedge mem_clk);
    check_idle_outputs("after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_short_tail();
    test_back_pressure();
    test_index_select();
    test_zero_length();
    test_restart();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
